// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch
//   Receive-side GMII frame dispatcher. Each incoming frame is checked for
//   preamble, SFD, destination MAC and EtherType. The whole frame, preamble
//   included, is then replayed with a fixed 22-cycle delay on the ARP port,
//   on the ICMP/IP port, or on neither (dropped). Because of the delay, the
//   routing decision is ready one cycle before byte 1 leaves the delay line.
//
// Ports
//   clk              GMII receive clock, rising edge
//   rst              asynchronous active-high reset
//   gmii_rx_dv/rxd   receive byte stream in
//   arp_gmii_rx_*    delayed stream for ARP-routed frames (zero otherwise)
//   icmp_gmii_rx_*   delayed stream for IP-routed frames (zero otherwise)
//   arp_cnt, ip_cnt, drop_cnt   saturating per-route frame counters
//   route_ovf        sticky: a route was discarded because the FIFO was full
//
// Input FSM
//   state     | meaning
//   WAIT_IDLE | after reset; ignore a frame already in progress
//   IDLE      | between frames, waiting for dv
//   HDR       | bytes 1..22: preamble, SFD, dest MAC, EtherType checks
//   BODY      | route already pushed; wait for end of frame
module eth_rx_dispatch #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_gmii_rx_dv,
  output logic [7:0]  arp_gmii_rxd,
  output logic        icmp_gmii_rx_dv,
  output logic [7:0]  icmp_gmii_rxd,
  output logic [15:0] arp_cnt,
  output logic [15:0] ip_cnt,
  output logic [15:0] drop_cnt,
  output logic        route_ovf
);

  localparam logic [1:0] ROUTE_DROP = 2'd0;
  localparam logic [1:0] ROUTE_ARP  = 2'd1;
  localparam logic [1:0] ROUTE_IP   = 2'd2;
  localparam int         DLY        = 22;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, HDR, BODY} state_t;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic        r_pre_ok;
  logic        r_ucast;
  logic        r_bcast;
  logic [7:0]  r_et_hi;

  logic [8:0]  r_dly [DLY];
  logic        r_dly_dv_q;

  logic [1:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [1:0]  r_out_route;

  logic        r_arp_dv;
  logic [7:0]  r_arp_rxd;
  logic        r_icmp_dv;
  logic [7:0]  r_icmp_rxd;
  logic [15:0] r_arp_cnt;
  logic [15:0] r_ip_cnt;
  logic [15:0] r_drop_cnt;
  logic        r_route_ovf;

  logic [4:0]  w_n;
  logic [7:0]  w_mac_byte;
  logic        w_push;
  logic [1:0]  w_push_route;
  logic        w_push_ok;
  logic [8:0]  w_dly_out;
  logic        w_sof;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic [1:0]  w_route_head;
  logic [1:0]  w_route_cur;

  // Byte index of the byte currently on gmii_rxd while in HDR.
  always_comb begin
    w_n = r_idx + 5'd1;
    case (w_n)
      5'd9:    w_mac_byte = BOARD_MAC[47:40];
      5'd10:   w_mac_byte = BOARD_MAC[39:32];
      5'd11:   w_mac_byte = BOARD_MAC[31:24];
      5'd12:   w_mac_byte = BOARD_MAC[23:16];
      5'd13:   w_mac_byte = BOARD_MAC[15:8];
      5'd14:   w_mac_byte = BOARD_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  // Route decision: on byte 22, or on a runt ending inside the header.
  always_comb begin
    w_push       = 1'b0;
    w_push_route = ROUTE_DROP;
    if (r_state == HDR) begin
      if (!gmii_rx_dv) begin
        w_push = 1'b1;
      end else if (w_n == 5'd22) begin
        w_push = 1'b1;
        if (r_pre_ok && (r_ucast || r_bcast)) begin
          if ({r_et_hi, gmii_rxd} == 16'h0806)      w_push_route = ROUTE_ARP;
          else if ({r_et_hi, gmii_rxd} == 16'h0800) w_push_route = ROUTE_IP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= WAIT_IDLE;
      r_idx    <= 5'd0;
      r_pre_ok <= 1'b0;
      r_ucast  <= 1'b0;
      r_bcast  <= 1'b0;
      r_et_hi  <= 8'h00;
    end else begin
      case (r_state)
        WAIT_IDLE: begin
          if (!gmii_rx_dv) r_state <= IDLE;
        end
        IDLE: begin
          if (gmii_rx_dv) begin
            r_state  <= HDR;
            r_idx    <= 5'd1;
            r_pre_ok <= (gmii_rxd == 8'h55);
            r_ucast  <= 1'b1;
            r_bcast  <= 1'b1;
          end
        end
        HDR: begin
          if (!gmii_rx_dv) begin
            r_state <= IDLE;
          end else begin
            r_idx <= w_n;
            if (w_n <= 5'd7) begin
              r_pre_ok <= r_pre_ok & (gmii_rxd == 8'h55);
            end else if (w_n == 5'd8) begin
              r_pre_ok <= r_pre_ok & (gmii_rxd == 8'hD5);
            end else if (w_n <= 5'd14) begin
              r_ucast <= r_ucast & (gmii_rxd == w_mac_byte);
              r_bcast <= r_bcast & (gmii_rxd == 8'hFF);
            end else if (w_n == 5'd21) begin
              r_et_hi <= gmii_rxd;
            end
            if (w_n == 5'd22) r_state <= BODY;
          end
        end
        BODY: begin
          if (!gmii_rx_dv) r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) r_dly[i] <= 9'h000;
    end else begin
      r_dly[0] <= {gmii_rx_dv, gmii_rxd};
      for (int i = 1; i < DLY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Start of a delayed frame pops its route; the pop is combinational so
  // byte 1 is already steered on the cycle it leaves the delay line.
  assign w_dly_out    = r_dly[DLY-1];
  assign w_sof        = w_dly_out[8] & ~r_dly_dv_q;
  assign w_empty      = (r_count == 3'd0);
  assign w_full       = (r_count == 3'd4);
  assign w_pop        = w_sof & ~w_empty;
  assign w_push_ok    = w_push & (~w_full | w_pop);
  assign w_route_head = w_empty ? ROUTE_DROP : r_fifo[r_rd_ptr];
  assign w_route_cur  = w_sof ? w_route_head : r_out_route;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= ROUTE_DROP;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_route_ovf <= 1'b0;
      r_out_route <= ROUTE_DROP;
      r_dly_dv_q  <= 1'b0;
    end else begin
      r_dly_dv_q <= w_dly_out[8];
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= w_push_route;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 3'd1;
      if (w_push && !w_push_ok) r_route_ovf <= 1'b1;
      if (w_sof)              r_out_route <= w_route_head;
      else if (!w_dly_out[8]) r_out_route <= ROUTE_DROP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arp_dv   <= 1'b0;
      r_arp_rxd  <= 8'h00;
      r_icmp_dv  <= 1'b0;
      r_icmp_rxd <= 8'h00;
    end else begin
      r_arp_dv   <= w_dly_out[8] && (w_route_cur == ROUTE_ARP);
      r_arp_rxd  <= (w_dly_out[8] && (w_route_cur == ROUTE_ARP)) ? w_dly_out[7:0] : 8'h00;
      r_icmp_dv  <= w_dly_out[8] && (w_route_cur == ROUTE_IP);
      r_icmp_rxd <= (w_dly_out[8] && (w_route_cur == ROUTE_IP)) ? w_dly_out[7:0] : 8'h00;
    end
  end

  // Counters follow the decision, even if the FIFO had to discard it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arp_cnt  <= 16'h0000;
      r_ip_cnt   <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else if (w_push) begin
      case (w_push_route)
        ROUTE_ARP: if (r_arp_cnt != 16'hFFFF) r_arp_cnt <= r_arp_cnt + 16'd1;
        ROUTE_IP:  if (r_ip_cnt != 16'hFFFF) r_ip_cnt <= r_ip_cnt + 16'd1;
        default:   if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      endcase
    end
  end

  assign arp_gmii_rx_dv  = r_arp_dv;
  assign arp_gmii_rxd    = r_arp_rxd;
  assign icmp_gmii_rx_dv = r_icmp_dv;
  assign icmp_gmii_rxd   = r_icmp_rxd;
  assign arp_cnt         = r_arp_cnt;
  assign ip_cnt          = r_ip_cnt;
  assign drop_cnt        = r_drop_cnt;
  assign route_ovf       = r_route_ovf;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Testbench for eth_rx_dispatch: directed frames from a table plus
// hand-written runt, reset and saturation sequences. A per-cycle expected
// output array is filled as bytes are driven and compared every cycle.
module tb_eth_rx_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        arp_gmii_rx_dv;
  logic [7:0]  arp_gmii_rxd;
  logic        icmp_gmii_rx_dv;
  logic [7:0]  icmp_gmii_rxd;
  logic [15:0] arp_cnt;
  logic [15:0] ip_cnt;
  logic [15:0] drop_cnt;
  logic        route_ovf;

  eth_rx_dispatch dut (
    .clk             (clk),
    .rst             (rst),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rxd        (gmii_rxd),
    .arp_gmii_rx_dv  (arp_gmii_rx_dv),
    .arp_gmii_rxd    (arp_gmii_rxd),
    .icmp_gmii_rx_dv (icmp_gmii_rx_dv),
    .icmp_gmii_rxd   (icmp_gmii_rxd),
    .arp_cnt         (arp_cnt),
    .ip_cnt          (ip_cnt),
    .drop_cnt        (drop_cnt),
    .route_ovf       (route_ovf)
  );

  always #5 clk = ~clk;

  localparam int NCYC = 4096;
  localparam logic [47:0] UCAST = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [17:0] exp_out [NCYC];
  logic [7:0]  fb [128];

  typedef struct packed {
    logic [47:0] mac;
    logic [7:0]  pre3;
    logic [7:0]  sfd;
    logic [15:0] et;
    logic [7:0]  len;
    logic [1:0]  rt;
    logic [15:0] arp;
    logic [15:0] ip;
    logic [15:0] drp;
  } vec_t;

  vec_t tbl [10];

  // Output sampled 1 time unit after each rising edge; {arp dv,rxd,icmp dv,rxd}.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc < NCYC) begin
      checks++;
      if ({arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd} !== exp_out[cyc]) begin
        failures++;
        $display("FAIL out_cyc%0d actual=%h required=%h", cyc,
                 {arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd}, exp_out[cyc]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // A byte driven now is sampled on the next edge and leaves 22 edges later.
  task automatic drive_byte(input logic dv, input logic [7:0] d, input logic [1:0] rt);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    if (dv && (cyc + 23 < NCYC)) begin
      if (rt == 2'd1)      exp_out[cyc+23] = {1'b1, d, 9'h000};
      else if (rt == 2'd2) exp_out[cyc+23] = {9'h000, 1'b1, d};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_byte(1'b0, 8'h00, 2'd0);
  endtask

  task automatic build(input logic [47:0] mac, input logic [7:0] pre3,
                       input logic [7:0] sfd, input logic [15:0] et, input int len);
    for (int i = 0; i < 128; i++) fb[i] = 8'((i * 7 + 3) & 255);
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[2] = pre3;
    fb[7] = sfd;
    for (int i = 0; i < 6; i++) fb[8+i] = mac[8*(5-i) +: 8];
    for (int i = 0; i < 6; i++) fb[14+i] = 8'(8'h02 + i);
    fb[20] = et[15:8];
    fb[21] = et[7:0];
  endtask

  task automatic send_frame(input logic [47:0] mac, input logic [7:0] pre3,
                            input logic [7:0] sfd, input logic [15:0] et,
                            input int len, input logic [1:0] rt);
    build(mac, pre3, sfd, et, len);
    for (int i = 0; i < len; i++) drive_byte(1'b1, fb[i], rt);
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) exp_out[i] = 18'h0;

    tbl[0] = '{BCAST,                8'h55, 8'hD5, 16'h0806, 8'd64, 2'd1, 16'd1, 16'd0, 16'd0};
    tbl[1] = '{UCAST,                8'h55, 8'hD5, 16'h0800, 8'd98, 2'd2, 16'd1, 16'd1, 16'd0};
    tbl[2] = '{48'h00_11_22_33_44_56, 8'h55, 8'hD5, 16'h0800, 8'd64, 2'd0, 16'd1, 16'd1, 16'd1};
    tbl[3] = '{BCAST,                8'h54, 8'hD5, 16'h0806, 8'd64, 2'd0, 16'd1, 16'd1, 16'd2};
    tbl[4] = '{UCAST,                8'h55, 8'hD5, 16'h86DD, 8'd70, 2'd0, 16'd1, 16'd1, 16'd3};
    tbl[5] = '{UCAST,                8'h55, 8'hD5, 16'h0806, 8'd60, 2'd1, 16'd2, 16'd1, 16'd3};
    tbl[6] = '{BCAST,                8'h55, 8'hD5, 16'h0800, 8'd64, 2'd2, 16'd2, 16'd2, 16'd3};
    tbl[7] = '{UCAST,                8'h55, 8'h55, 16'h0800, 8'd64, 2'd0, 16'd2, 16'd2, 16'd4};
    tbl[8] = '{UCAST,                8'h55, 8'hD5, 16'h0808, 8'd64, 2'd0, 16'd2, 16'd2, 16'd5};
    tbl[9] = '{48'h80_11_22_33_44_55, 8'h55, 8'hD5, 16'h0806, 8'd64, 2'd0, 16'd2, 16'd2, 16'd6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_arp_cnt", 32'(arp_cnt), 32'd0);
    chk("rst_ip_cnt", 32'(ip_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(route_ovf), 32'd0);
    idle(3);

    for (int v = 0; v < 10; v++) begin
      send_frame(tbl[v].mac, tbl[v].pre3, tbl[v].sfd, tbl[v].et, int'(tbl[v].len), tbl[v].rt);
      idle(12);
      chk($sformatf("v%0d_arp_cnt", v), 32'(arp_cnt), 32'(tbl[v].arp));
      chk($sformatf("v%0d_ip_cnt", v), 32'(ip_cnt), 32'(tbl[v].ip));
      chk($sformatf("v%0d_drop_cnt", v), 32'(drop_cnt), 32'(tbl[v].drp));
    end
    idle(30);

    // Runt followed by back-to-back minimum-gap frames.
    send_frame(BCAST, 8'h55, 8'hD5, 16'h0806, 10, 2'd0);
    idle(12);
    send_frame(BCAST, 8'h55, 8'hD5, 16'h0806, 60, 2'd1);
    idle(12);
    send_frame(UCAST, 8'h55, 8'hD5, 16'h0800, 70, 2'd2);
    idle(30);
    chk("runt_arp_cnt", 32'(arp_cnt), 32'd3);
    chk("runt_ip_cnt", 32'(ip_cnt), 32'd3);
    chk("runt_drop_cnt", 32'(drop_cnt), 32'd7);
    chk("runt_ovf", 32'(route_ovf), 32'd0);

    // Reset at byte 30 of an IP frame, released three cycles later with dv high.
    build(UCAST, 8'h55, 8'hD5, 16'h0800, 98);
    for (int i = 0; i < 29; i++) drive_byte(1'b1, fb[i], 2'd2);
    chk("pre_rst_icmp_dv", 32'(icmp_gmii_rx_dv), 32'd1);
    chk("pre_rst_icmp_rxd", 32'(icmp_gmii_rxd), 32'(fb[5]));
    @(negedge clk);
    rst = 1'b1;
    gmii_rx_dv = 1'b1;
    gmii_rxd = fb[29];
    for (int i = cyc + 1; i < cyc + 40 && i < NCYC; i++) exp_out[i] = 18'h0;
    #1;
    chk("rst_mid_outs", 32'({arp_gmii_rx_dv, arp_gmii_rxd, icmp_gmii_rx_dv, icmp_gmii_rxd}), 32'd0);
    chk("rst_mid_ip_cnt", 32'(ip_cnt), 32'd0);
    chk("rst_mid_arp_cnt", 32'(arp_cnt), 32'd0);
    drive_byte(1'b1, fb[30], 2'd0);
    drive_byte(1'b1, fb[31], 2'd0);
    drive_byte(1'b1, fb[32], 2'd0);
    rst = 1'b0;
    for (int i = 33; i < 98; i++) drive_byte(1'b1, fb[i], 2'd0);
    idle(12);
    send_frame(BCAST, 8'h55, 8'hD5, 16'h0806, 64, 2'd1);
    idle(30);
    chk("post_rst_arp_cnt", 32'(arp_cnt), 32'd1);
    chk("post_rst_ip_cnt", 32'(ip_cnt), 32'd0);
    chk("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("post_rst_ovf", 32'(route_ovf), 32'd0);

    // Saturation: preload the ARP counter near the top, then send three frames.
    @(negedge clk);
    force dut.r_arp_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_arp_cnt;
    chk("sat_preload", 32'(arp_cnt), 32'h0000FFFE);
    send_frame(UCAST, 8'h55, 8'hD5, 16'h0806, 64, 2'd1);
    idle(12);
    chk("sat_arp_cnt_1", 32'(arp_cnt), 32'h0000FFFF);
    send_frame(UCAST, 8'h55, 8'hD5, 16'h0806, 64, 2'd1);
    idle(12);
    send_frame(BCAST, 8'h55, 8'hD5, 16'h0806, 64, 2'd1);
    idle(30);
    chk("sat_arp_cnt_3", 32'(arp_cnt), 32'h0000FFFF);
    chk("sat_ip_cnt", 32'(ip_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_dispatch.md
# eth_rx_dispatch

Receive-side frame dispatcher between the GMII receive interface and the per-protocol receivers (ARP receiver, ICMP/IP receiver). It checks preamble, SFD, destination MAC and EtherType, then forwards each whole frame, preamble included, to exactly one receiver port or drops it. Frames leave with a fixed 22-cycle delay, so the routing decision is known before the first byte is forwarded. It also keeps saturating per-route frame counters for debug.

## Interface
- BOARD_MAC, 48'h00_11_22_33_44_55, station MAC accepted as destination. 48'hFF_FF_FF_FF_FF_FF (broadcast) is always accepted.
- clk  in  1  GMII receive clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rxd  in  8  receive byte.
- arp_gmii_rx_dv  out  1  delayed dv, asserted only for ARP-routed frames.
- arp_gmii_rxd  out  8  delayed byte; 8'h00 whenever arp_gmii_rx_dv=0.
- icmp_gmii_rx_dv  out  1  delayed dv, asserted only for IP-routed frames.
- icmp_gmii_rxd  out  8  delayed byte; 8'h00 whenever icmp_gmii_rx_dv=0.
- arp_cnt  out  16  ARP frames routed; saturates at 16'hFFFF.
- ip_cnt  out  16  IP frames routed; saturates.
- drop_cnt  out  16  frames dropped; saturates.
- route_ovf  out  1  sticky flag: route FIFO overflowed.

## Operation
- **Delay line.** A 22-entry shift register of {dv, rxd}, 9 bits wide, advances every cycle.
- **Input FSM states:** WAIT_IDLE, IDLE, HDR, BODY. The byte index n counts 1..22 within the frame.
  - WAIT_IDLE is entered on reset. It moves to IDLE on the first cycle with gmii_rx_dv=0, so a frame already in progress when reset releases is ignored entirely (no route, no counter change).
  - IDLE moves to HDR when dv=1. That byte is n=1.
  - In HDR, bytes are checked as follows:
    - n=1..7 must be 8'h55, and n=8 must be 8'hD5.
    - n=9..14 are the destination MAC, most significant byte first; it must equal BOARD_MAC or broadcast.
    - n=21..22 are the EtherType: 16'h0806 routes ARP, 16'h0800 routes IP, anything else routes DROP.
    - Any earlier mismatch forces DROP.
  - At n=22 the route is pushed to the route FIFO and the FSM moves to BODY.
  - If dv falls in HDR (runt, fewer than 22 bytes), DROP is pushed and the FSM moves to IDLE.
  - BODY moves to IDLE when dv=0.
- **Route FIFO.** 4 deep, 2-bit entries (ARP=1, IP=2, DROP=0).
  - It is popped when the delay-line output shows a dv rising edge (start of frame). The popped value is held in out_route until the delayed dv falls.
  - A pop on an empty FIFO gives DROP.
  - A push on a full FIFO discards the new entry and sets route_ovf. Only reset clears route_ovf.
- **Output steering.** For each delayed byte with dv=1:
  - out_route=ARP drives the arp_* ports.
  - out_route=IP drives the icmp_* ports.
  - out_route=DROP drives neither.
  - Unselected ports output dv=0 and rxd=0.
- **Counters.** Each counter increments by 1 on the push of its route and holds at 16'hFFFF.
- **Reset values.** All outputs and counters are 0, the delay line is cleared (all dv=0), the FIFO is empty and the FSM is in WAIT_IDLE. Reset mid-frame aborts both the input and the output side immediately; no partial frame is emitted after reset.

## Timing
- **Latency.** A byte sampled on edge k appears on the output registers after edge k+22, exactly. dv and data stay aligned and gaps inside dv are preserved.
- **Decision timing.** The route is pushed on the edge that samples byte 22, which is one cycle before byte 1 reaches the output. This cycle of margin is guaranteed.
- **Throughput.** One byte per cycle, with no backpressure.
- **Supported gap.** The inter-frame gap is at least 12 dv-low cycles (GMII IPG). This keeps at most 2 routes in flight, so the FIFO does not overflow in normal operation.
- **Simultaneous push and pop** in the same cycle are both performed; occupancy is unchanged.

## Test plan
- **ARP broadcast.** Preamble/SFD, destination FF:FF:FF:FF:FF:FF, type 0x0806, 42-byte payload, 64 bytes total. Required: the arp_* ports replay all 64 bytes starting 22 cycles after input byte 1; icmp_gmii_rx_dv stays 0; arp_cnt=1.
- **IP unicast.** Destination 00:11:22:33:44:55, type 0x0800, 98 bytes. Required: the icmp_* ports replay it with 22-cycle latency; ip_cnt=1; arp ports idle.
- **Drops.** Three frames: destination 00:11:22:33:44:56, a preamble with byte 3 = 8'h54, and type 0x86DD. Required: no dv on any output; drop_cnt=3.
- **Runt then back-to-back.** A 10-byte runt, 12-cycle gap, an ARP frame, 12-cycle gap, an IP frame. Required: drop_cnt=1; the ARP frame appears only on the arp ports and the IP frame only on the icmp ports, each aligned; route_ovf=0.
- **Reset mid-frame.** Assert rst at input byte 30 of an IP frame, release it 3 cycles later while dv is still 1. Required: all outputs are 0 within the reset cycle; the rest of the frame is never emitted; counters=0; the next valid ARP frame is routed normally.
- **Saturation.** Preload traffic of 65,537 ARP frames (or force the counter to 16'hFFFE and send 3 frames). Required: arp_cnt holds at 16'hFFFF.
